alu_sequencer: RTL and testbench

- Multi-cycle controller that sequences the 16-bit ALU for one instruction at a time.
- Owns a 16x16 register file and the 5-bit flag register (PSR).
- Accepts instructions on a valid/ready handshake, reads two operands, drives the ALU, then writes back the result and/or flags.
- Sits between instruction fetch/decode and the ALU instance; the ALU stays purely combinational.

---
 rtl/alu_sequencer_if.sv | 37 +++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU bus and status/debug signals of the ALU sequencer.
//   slave  : the sequencer side (takes instructions and ALU results, drives ALU operands).
//   master : the environment side (instruction source, ALU instance, debug reader).
// Signals:
//   instr_valid/instr_ready/instr  instruction handshake ([15:12] op, [11:8] rd, [7:4] rs)
//   done                           one-cycle pulse in the writeback cycle
//   alu_a/alu_b/alu_op/alu_cin     registered operands, opcode and carry-in towards the ALU
//   alu_c/alu_flags                combinational ALU result and flags {Z, C, F, L, N}
//   psr                            current flag register
//   dbg_addr/dbg_data              combinational register-file read port
interface alu_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [15:0]      instr;
    logic             done;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_c;
    logic [4:0]       alu_flags;
    logic [4:0]       psr;
    logic [3:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport slave (
        input  instr_valid, instr, alu_c, alu_flags, dbg_addr,
        output instr_ready, done, alu_a, alu_b, alu_op, alu_cin, psr, dbg_data
    );

    modport master (
        output instr_valid, instr, alu_c, alu_flags, dbg_addr,
        input  instr_ready, done, alu_a, alu_b, alu_op, alu_cin, psr, dbg_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing a combinational 16-bit ALU, one instruction at a time.
// Owns the register file and the 5-bit flag register (psr {Z, C, F, L, N}).
// Flow per instruction: IDLE (accept) -> READ (latch operands) -> EXEC (latch ALU result)
// -> WB (done pulse, commit) -> IDLE, i.e. one instruction every 4 clocks.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_sequencer_if.slave (instruction handshake, ALU bus, psr, debug read port)
module alu_sequencer #(
    parameter int unsigned NREG  = 16,
    parameter int unsigned WIDTH = 16
) (
    input logic            clk,
    input logic            rst_n,
    alu_sequencer_if.slave bus
);
    localparam logic [3:0] OpLoadi = 4'b0000;
    localparam logic [3:0] OpAnd   = 4'b0001;
    localparam logic [3:0] OpOr    = 4'b0010;
    localparam logic [3:0] OpXor   = 4'b0011;
    localparam logic [3:0] OpAddcu = 4'b0100;
    localparam logic [3:0] OpAdd   = 4'b0101;
    localparam logic [3:0] OpAddu  = 4'b0110;
    localparam logic [3:0] OpAddc  = 4'b0111;
    localparam logic [3:0] OpCmpu  = 4'b1000;
    localparam logic [3:0] OpSub   = 4'b1001;
    localparam logic [3:0] OpMov   = 4'b1010;
    localparam logic [3:0] OpCmp   = 4'b1011;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e           state_q, state_d;
    logic             started_q;
    logic [15:0]      ir_q;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] alu_a_q, alu_b_q, res_q;
    logic [3:0]       alu_op_q;
    logic [4:0]       fl_q, psr_q, psr_d;
    logic             reg_we, accept;
    logic [WIDTH-1:0] wb_data;
    logic [3:0]       op, rd, rs;

    assign op = ir_q[15:12];
    assign rd = ir_q[11:8];
    assign rs = ir_q[7:4];

    // started_q keeps instr_ready low until the first clock after reset release.
    assign bus.instr_ready = (state_q == StIdle) && started_q;
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign bus.done        = (state_q == StWb);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_cin     = psr_q[3];
    assign bus.psr         = psr_q;
    assign bus.dbg_data    = regs_q[bus.dbg_addr];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StRead;
            StRead:  state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Writeback commit; nothing is written outside the WB cycle.
    always_comb begin
        reg_we  = 1'b0;
        wb_data = res_q;
        psr_d   = psr_q;
        if (state_q == StWb) begin
            unique case (op)
                OpAdd, OpAddc, OpSub: begin
                    reg_we     = 1'b1;
                    psr_d[4:2] = fl_q[4:2];
                end
                OpAddu, OpAddcu: begin
                    reg_we     = 1'b1;
                    psr_d[4:3] = fl_q[4:3];
                end
                OpCmp, OpCmpu: begin
                    psr_d[1:0] = fl_q[1:0];
                end
                OpAnd, OpOr, OpXor: begin
                    reg_we   = 1'b1;
                    psr_d[4] = fl_q[4];
                end
                OpLoadi: begin
                    reg_we  = 1'b1;
                    wb_data = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
                end
                // alu_b_q still holds R[rs] from READ.
                OpMov: begin
                    reg_we  = 1'b1;
                    wb_data = alu_b_q;
                end
                // Shifts: result only, flags untouched.
                default: begin
                    reg_we = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            started_q <= 1'b0;
            ir_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            res_q     <= '0;
            fl_q      <= '0;
            psr_q     <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            psr_q     <= psr_d;
            if (accept) begin
                ir_q <= bus.instr;
            end
            if (state_q == StRead) begin
                alu_a_q  <= regs_q[rd];
                alu_b_q  <= regs_q[rs];
                alu_op_q <= op;
            end
            if (state_q == StExec) begin
                res_q <= bus.alu_c;
                fl_q  <= bus.alu_flags;
            end
            if (reg_we) begin
                regs_q[rd] <= wb_data;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    localparam logic [3:0] OpLoadi = 4'b0000;
    localparam logic [3:0] OpAnd   = 4'b0001;
    localparam logic [3:0] OpOr    = 4'b0010;
    localparam logic [3:0] OpXor   = 4'b0011;
    localparam logic [3:0] OpAddcu = 4'b0100;
    localparam logic [3:0] OpAdd   = 4'b0101;
    localparam logic [3:0] OpAddu  = 4'b0110;
    localparam logic [3:0] OpAddc  = 4'b0111;
    localparam logic [3:0] OpCmpu  = 4'b1000;
    localparam logic [3:0] OpSub   = 4'b1001;
    localparam logic [3:0] OpMov   = 4'b1010;
    localparam logic [3:0] OpCmp   = 4'b1011;
    localparam logic [3:0] OpLsh   = 4'b1100;
    localparam logic [3:0] OpRsh   = 4'b1101;
    localparam logic [3:0] OpAlsh  = 4'b1110;
    localparam logic [3:0] OpArsh  = 4'b1111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] ref_regs [16];
    logic [4:0]  ref_psr;

    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(16)) bus ();

    alu_sequencer #(.NREG(16), .WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stand-in ALU. Flags {Z, C, F, L, N}: C is carry (borrow for subtract/compare),
    // F signed overflow, L = a > b unsigned, N = a < b signed.
    function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] c;
        logic        cf, ff, z, l, n;
        s  = '0;
        c  = '0;
        cf = 1'b0;
        ff = 1'b0;
        case (op)
            OpAdd, OpAddu, OpAddc, OpAddcu: begin
                s  = {1'b0, a} + {1'b0, b} +
                     {16'h0, ((op == OpAddc) || (op == OpAddcu)) ? cin : 1'b0};
                c  = s[15:0];
                cf = s[16];
                ff = (a[15] == b[15]) && (c[15] != a[15]);
            end
            OpSub, OpCmp, OpCmpu: begin
                s  = {1'b0, a} - {1'b0, b};
                c  = s[15:0];
                cf = s[16];
                ff = (a[15] != b[15]) && (c[15] != a[15]);
            end
            OpAnd:         c = a & b;
            OpOr:          c = a | b;
            OpXor:         c = a ^ b;
            OpLsh, OpAlsh: c = (b > 16'd15) ? 16'h0 : (a << b[3:0]);
            OpRsh:         c = (b > 16'd15) ? 16'h0 : (a >> b[3:0]);
            OpArsh:        c = (b > 16'd15) ? {16{a[15]}} : 16'($signed(a) >>> b[3:0]);
            default:       c = b;
        endcase
        z = (c == 16'h0);
        l = (a > b);
        n = ($signed(a) < $signed(b));
        return {z, cf, ff, l, n, c};
    endfunction

    always_comb {bus.alu_flags, bus.alu_c} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);

    // Instruction-level reference: one call per committed instruction.
    function automatic void ref_step(input logic [15:0] ins);
        logic [3:0]  op, rd, rs;
        logic [15:0] c;
        logic [4:0]  fl;
        op = ins[15:12];
        rd = ins[11:8];
        rs = ins[7:4];
        {fl, c} = alu_fn(op, ref_regs[rd], ref_regs[rs], ref_psr[3]);
        case (op)
            OpLoadi:              ref_regs[rd] = {8'h00, ins[7:0]};
            OpMov:                ref_regs[rd] = ref_regs[rs];
            OpAdd, OpAddc, OpSub: begin ref_regs[rd] = c; ref_psr[4:2] = fl[4:2]; end
            OpAddu, OpAddcu:      begin ref_regs[rd] = c; ref_psr[4:3] = fl[4:3]; end
            OpCmp, OpCmpu:        ref_psr[1:0] = fl[1:0];
            OpAnd, OpOr, OpXor:   begin ref_regs[rd] = c; ref_psr[4] = fl[4]; end
            default:              ref_regs[rd] = c;
        endcase
    endfunction

    function automatic void ref_reset();
        for (int i = 0; i < 16; i++) ref_regs[i] = 16'h0;
        ref_psr = 5'h0;
    endfunction

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs);
        return {op, rd, rs, 4'h0};
    endfunction

    function automatic logic [15:0] enc_imm(input logic [3:0] rd, input logic [7:0] imm);
        return {OpLoadi, rd, imm};
    endfunction

    task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
        bus.dbg_addr = a;
        #1;
        v = bus.dbg_data;
    endtask

    // Runs one instruction; returns accept-to-done latency in clocks and alu_cin during EXEC.
    // Ends at the negedge after the writeback edge, with the model updated.
    task automatic issue(input logic [15:0] ins, output int lat, output logic cin_exec);
        int n;
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        n = 0;
        while (bus.instr_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 16) begin
                $display("FAIL accept_timeout: instr_ready=%b required 1", bus.instr_ready);
                $fatal(1);
            end
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        lat      = 1;
        cin_exec = 1'b0;
        while (bus.done !== 1'b1) begin
            if (lat == 2) cin_exec = bus.alu_cin;
            @(negedge clk);
            lat++;
            if (lat > 16) begin
                $display("FAIL done_timeout: done=%b required 1", bus.done);
                $fatal(1);
            end
        end
        @(negedge clk);
        ref_step(ins);
    endtask

    task automatic test_reset;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0;
        bus.dbg_addr    = 4'h0;
        rst_n           = 1'b0;
        ref_reset();
        #12;
        checks++; if (bus.instr_ready !== 1'b0) begin errors++;
            $display("FAIL rst_ready: got %b want 0", bus.instr_ready); end
        checks++; if (bus.done !== 1'b0) begin errors++;
            $display("FAIL rst_done: got %b want 0", bus.done); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 36'h0) begin errors++;
            $display("FAIL rst_alu: got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_op}); end
        checks++; if (bus.psr !== 5'h0) begin errors++;
            $display("FAIL rst_psr: got %h want 0", bus.psr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.instr_ready !== 1'b1) begin errors++;
            $display("FAIL rst_release_ready: got %b want 1", bus.instr_ready); end
    endtask

    task automatic test_reset_mid_exec;
        int lat; logic cin; logic [15:0] v; int seen_done;
        issue(enc_imm(4'd1, 8'h55), lat, cin);
        issue(enc_imm(4'd2, 8'h00), lat, cin);
        issue(enc(OpAddu, 4'd2, 4'd2), lat, cin);
        checks++; if (bus.psr !== ref_psr) begin errors++;
            $display("FAIL pre_reset_psr: got %h want %h", bus.psr, ref_psr); end
        bus.instr       = enc(OpAdd, 4'd1, 4'd1);
        bus.instr_valid = 1'b1;
        seen_done = 0;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        if (bus.done === 1'b1) seen_done++;
        @(negedge clk);
        if (bus.done === 1'b1) seen_done++;
        rst_n = 1'b0;
        ref_reset();
        #1;
        checks++; if (bus.instr_ready !== 1'b0) begin errors++;
            $display("FAIL midrst_ready: got %b want 0", bus.instr_ready); end
        checks++; if (bus.psr !== 5'h0) begin errors++;
            $display("FAIL midrst_psr: got %h want 0", bus.psr); end
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), v);
            checks++; if (v !== 16'h0) begin errors++;
                $display("FAIL midrst_reg%0d: got %h want 0", i, v); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if (bus.done === 1'b1) seen_done++;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++;
            $display("FAIL midrst_release_ready: got %b want 1", bus.instr_ready); end
        @(negedge clk);
        if (bus.done === 1'b1) seen_done++;
        checks++; if (seen_done != 0) begin errors++;
            $display("FAIL midrst_no_done: got %0d pulses want 0", seen_done); end
    endtask

    task automatic test_loadi_shift;
        int l1, l2, l3; logic cin; logic [15:0] v;
        issue(enc_imm(4'd1, 8'h7F), l1, cin);
        issue(enc_imm(4'd2, 8'h01), l2, cin);
        issue(enc(OpLsh, 4'd1, 4'd2), l3, cin);
        checks++; if (l1 != 3) begin errors++; $display("FAIL lat_loadi1: got %0d want 3", l1); end
        checks++; if (l2 != 3) begin errors++; $display("FAIL lat_loadi2: got %0d want 3", l2); end
        checks++; if (l3 != 3) begin errors++; $display("FAIL lat_lsh: got %0d want 3", l3); end
        read_reg(4'd1, v);
        checks++; if (v !== 16'h00FE || v !== ref_regs[1]) begin errors++;
            $display("FAIL lsh_r1: got %h want 00fe", v); end
        checks++; if (bus.psr !== 5'h0) begin errors++;
            $display("FAIL lsh_psr: got %h want 0", bus.psr); end
    endtask

    task automatic test_shift_saturate;
        int lat; logic cin; logic [15:0] v; logic [4:0] p0;
        issue(enc_imm(4'd3, 8'hFF), lat, cin);
        p0 = ref_psr;
        issue(enc(OpAlsh, 4'd3, 4'd3), lat, cin);
        read_reg(4'd3, v);
        checks++; if (v !== 16'h0000) begin errors++;
            $display("FAIL alsh255_r3: got %h want 0000", v); end
        checks++; if (bus.psr !== p0) begin errors++;
            $display("FAIL alsh255_psr: got %h want %h", bus.psr, p0); end
        issue(enc(OpAddu, 4'd3, 4'd3), lat, cin);
        checks++; if (bus.psr[4:3] !== 2'b10) begin errors++;
            $display("FAIL addu_zero_zc: got %b want 10", bus.psr[4:3]); end
    endtask

    task automatic test_carry;
        int lat; logic cin; logic [15:0] v;
        issue(enc_imm(4'd5, 8'h01), lat, cin);
        issue(enc(OpSub, 4'd4, 4'd5), lat, cin);
        read_reg(4'd4, v);
        checks++; if (v !== 16'hFFFF) begin errors++;
            $display("FAIL sub_r4: got %h want ffff", v); end
        issue(enc(OpAddu, 4'd4, 4'd5), lat, cin);
        read_reg(4'd4, v);
        checks++; if (v !== 16'h0000) begin errors++;
            $display("FAIL addu_r4: got %h want 0000", v); end
        checks++; if (bus.psr[4:3] !== 2'b11) begin errors++;
            $display("FAIL addu_zc: got %b want 11", bus.psr[4:3]); end
        issue(enc(OpAddcu, 4'd5, 4'd0), lat, cin);
        read_reg(4'd5, v);
        checks++; if (v !== 16'h0002) begin errors++;
            $display("FAIL addcu_r5: got %h want 0002", v); end
        checks++; if (cin !== 1'b1) begin errors++;
            $display("FAIL addcu_cin: got %b want 1", cin); end
    endtask

    task automatic test_overflow_cmp;
        int lat; logic cin; logic [15:0] v;
        issue(enc_imm(4'd6, 8'h80), lat, cin);
        issue(enc_imm(4'd7, 8'h08), lat, cin);
        issue(enc(OpLsh, 4'd6, 4'd7), lat, cin);
        issue(enc_imm(4'd7, 8'h01), lat, cin);
        issue(enc(OpSub, 4'd6, 4'd7), lat, cin);
        read_reg(4'd6, v);
        checks++; if (v !== 16'h7FFF) begin errors++;
            $display("FAIL build_r6: got %h want 7fff", v); end
        issue(enc(OpAdd, 4'd6, 4'd7), lat, cin);
        read_reg(4'd6, v);
        checks++; if (v !== 16'h8000) begin errors++;
            $display("FAIL add_ovf_r6: got %h want 8000", v); end
        checks++; if ({bus.psr[4], bus.psr[2]} !== 2'b01) begin errors++;
            $display("FAIL add_ovf_zf: got %b want 01", {bus.psr[4], bus.psr[2]}); end
        issue(enc(OpCmp, 4'd6, 4'd7), lat, cin);
        checks++; if (bus.psr[2:0] !== 3'b111) begin errors++;
            $display("FAIL cmp_fln: got %b want 111", bus.psr[2:0]); end
        read_reg(4'd6, v);
        checks++; if (v !== 16'h8000) begin errors++;
            $display("FAIL cmp_r6_kept: got %h want 8000", v); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] q [4];
        int acc [4];
        int k, cyc, ndone;
        logic [15:0] v;
        q[0] = enc_imm(4'd8, 8'h11);
        q[1] = enc_imm(4'd9, 8'h22);
        q[2] = enc(OpMov, 4'd10, 4'd9);
        q[3] = enc_imm(4'd8, 8'h33);
        k = 0; cyc = 0; ndone = 0;
        for (int i = 0; i < 4; i++) acc[i] = 0;
        @(negedge clk);
        bus.instr       = q[0];
        bus.instr_valid = 1'b1;
        while (cyc < 60 && !(k == 4 && ndone == 4)) begin
            if (bus.done === 1'b1) ndone++;
            if (k < 4 && bus.instr_ready === 1'b1) begin
                acc[k] = cyc;
                k++;
            end
            @(negedge clk);
            cyc++;
            if (k < 4) bus.instr = q[k];
            else bus.instr_valid = 1'b0;
        end
        bus.instr_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) ref_step(q[i]);
        checks++; if (k != 4) begin errors++; $display("FAIL b2b_accepts: got %0d want 4", k); end
        checks++; if (ndone != 4) begin errors++; $display("FAIL b2b_dones: got %0d want 4", ndone); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (acc[i] - acc[i-1] != 4) begin errors++;
                $display("FAIL b2b_gap%0d: got %0d want 4", i, acc[i] - acc[i-1]); end
        end
        read_reg(4'd8, v);
        checks++; if (v !== 16'h0033) begin errors++; $display("FAIL b2b_r8: got %h want 0033", v); end
        read_reg(4'd9, v);
        checks++; if (v !== 16'h0022) begin errors++; $display("FAIL b2b_r9: got %h want 0022", v); end
        read_reg(4'd10, v);
        checks++; if (v !== 16'h0022) begin errors++; $display("FAIL b2b_r10: got %h want 0022", v); end
    endtask

    task automatic test_random;
        int lat; logic cin; logic [15:0] ins, v;
        for (int n = 0; n < 40; n++) begin
            ins = 16'($urandom);
            issue(ins, lat, cin);
            read_reg(ins[11:8], v);
            checks++; if (v !== ref_regs[ins[11:8]]) begin errors++;
                $display("FAIL rand%0d_reg instr=%h: got %h want %h", n, ins, v, ref_regs[ins[11:8]]); end
            checks++; if (bus.psr !== ref_psr) begin errors++;
                $display("FAIL rand%0d_psr instr=%h: got %h want %h", n, ins, bus.psr, ref_psr); end
        end
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), v);
            checks++; if (v !== ref_regs[i]) begin errors++;
                $display("FAIL rand_final_r%0d: got %h want %h", i, v, ref_regs[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_loadi_shift();
        test_shift_saturate();
        test_carry();
        test_overflow_cmp();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
